// File: rtl/mesh_term_injector_if.sv
// Write-side and router-side signal bundle for mesh_term_injector.
// The slave modport is the injector itself; the master modport is the traffic source / router model.
interface mesh_term_injector_if #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4
);
  localparam int CW = $clog2(fifo_depth + 1);

  // Handshake: the source asserts wr_en for one cycle per packet and must watch full itself.
  // A push while full is dropped and recorded in overflow.
  // Toward the router, pndng_i_in is the valid and data_out_i_in the head word.
  // popin is a one-cycle pulse meaning the head was taken; the next head appears one cycle later.
  // A popin with nothing pending is dropped and recorded in underflow.
  logic                  wr_en;
  logic [3:0]            dst_row;
  logic [3:0]            dst_colum;
  logic                  mode;
  logic [pckg_sz-18:0]   payload;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  bad_dst;
  logic                  pndng_i_in;
  logic [pckg_sz-1:0]    data_out_i_in;
  logic                  popin;

  modport master (
    output wr_en, dst_row, dst_colum, mode, payload, popin,
    input  full, count, overflow, underflow, bad_dst, pndng_i_in, data_out_i_in
  );

  modport slave (
    input  wr_en, dst_row, dst_colum, mode, payload, popin,
    output full, count, overflow, underflow, bad_dst, pndng_i_in, data_out_i_in
  );
endinterface

// File: rtl/mesh_term_injector.sv
// Terminal injection FIFO feeding one external port of the mesh router.
// Optional destination legality check is enabled by defining INJ_ADDR_CHK_EN.
module mesh_term_injector #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mesh_term_injector_if.slave    bus
);

  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(fifo_depth);
  localparam logic [PW-1:0] PTR_LAST   = PW'(fifo_depth - 1);

  // The header only has 4-bit row/column fields, so the mesh plus its border must fit in 0..15.
  if (pckg_sz < 18 || fifo_depth < 2 || ROWS < 1 || ROWS > 14 ||
      COLUMS < 1 || COLUMS > 14) begin : g_bad_params
    $error("mesh_term_injector: unsupported parameter set");
  end

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_nxt;
  logic               overflow_q;
  logic               underflow_q;

  logic [pckg_sz-1:0] pkt;
  logic               full_w;
  logic               empty_w;
  logic               dst_legal;
  logic               push_ok;
  logic               pop_ok;
  logic               push_rej_full;
  logic               pop_rej_empty;

  assign pkt     = {8'h00, bus.dst_row, bus.dst_colum, bus.mode, bus.payload};
  assign full_w  = (count_q == COUNT_FULL);
  assign empty_w = (count_q == '0);

`ifdef INJ_ADDR_CHK_EN
  logic row_edge;
  logic col_edge;
  logic row_in;
  logic col_in;
  logic push_rej_dst;
  logic bad_dst_q;

  // Terminals sit on the border ring just outside the ROWS x COLUMS router grid, corners excluded.
  assign row_edge  = (bus.dst_row == 4'd0) || (int'(bus.dst_row) == ROWS + 1);
  assign col_edge  = (bus.dst_colum == 4'd0) || (int'(bus.dst_colum) == COLUMS + 1);
  assign row_in    = (int'(bus.dst_row) >= 1) && (int'(bus.dst_row) <= ROWS);
  assign col_in    = (int'(bus.dst_colum) >= 1) && (int'(bus.dst_colum) <= COLUMS);
  assign dst_legal = (row_edge && col_in) || (col_edge && row_in);
  assign push_rej_dst = bus.wr_en && !dst_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_dst_q <= 1'b0;
    end else if (push_rej_dst) begin
      bad_dst_q <= 1'b1;
    end
  end

  assign bus.bad_dst = bad_dst_q;
`else
  assign dst_legal   = 1'b1;
  assign bus.bad_dst = 1'b0;
`endif

  // full comes from registered count, so a same-cycle pop never makes room for a push.
  assign push_ok       = bus.wr_en && !full_w && dst_legal;
  assign pop_ok        = bus.popin && !empty_w;
  assign push_rej_full = bus.wr_en && full_w;
  assign pop_rej_empty = bus.popin && empty_w;

  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_rej_full) begin
        overflow_q <= 1'b1;
      end
      if (pop_rej_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.full          = full_w;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
  assign bus.pndng_i_in    = !empty_w;
  assign bus.data_out_i_in = empty_w ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_mesh_term_injector.sv
// Directed bench for mesh_term_injector: packet format, FIFO order, full/empty corners, sticky flags.
module tb_mesh_term_injector;

  localparam int PK = 40;
  localparam int FD = 4;
  localparam int CW = $clog2(FD + 1);

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  mesh_term_injector_if #(.pckg_sz(PK), .fifo_depth(FD)) bus ();

  mesh_term_injector #(.ROWS(4), .COLUMS(4), .pckg_sz(PK), .fifo_depth(FD)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PK-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                           input logic m, input logic [PK-18:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  // drivers: called at a negedge, apply one posedge, return at the next negedge
  task automatic do_reset();
    rst = 1'b1; bus.wr_en = 1'b0; bus.popin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [PK-18:0] p);
    bus.wr_en = 1'b1; bus.dst_row = r; bus.dst_colum = c; bus.mode = m; bus.payload = p;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pop();
    bus.popin = 1'b1;
    @(negedge clk);
    bus.popin = 1'b0;
  endtask

  task automatic push_pop(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [PK-18:0] p);
    bus.wr_en = 1'b1; bus.popin = 1'b1;
    bus.dst_row = r; bus.dst_colum = c; bus.mode = m; bus.payload = p;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.popin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.count !== CW'(0)) $display("FAIL reset_count got=%0d exp=0", bus.count); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full); else pass_cnt++;
    total_cnt++; if ({bus.overflow, bus.underflow, bus.bad_dst} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.overflow, bus.underflow, bus.bad_dst}); else pass_cnt++;
    total_cnt++; if (bus.pndng_i_in !== 1'b0) $display("FAIL reset_pndng got=%b exp=0", bus.pndng_i_in); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== '0) $display("FAIL reset_data got=%h exp=0", bus.data_out_i_in); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    push(4'd0, 4'd2, 1'b1, 23'd1);
    total_cnt++; if (bus.pndng_i_in !== 1'b1) $display("FAIL basic_pndng got=%b exp=1", bus.pndng_i_in); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== 40'h0002800001)
      $display("FAIL basic_data got=%h exp=0002800001", bus.data_out_i_in); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(1)) $display("FAIL basic_count got=%0d exp=1", bus.count); else pass_cnt++;
    pop();
    total_cnt++; if (bus.pndng_i_in !== 1'b0) $display("FAIL basic_pop_pndng got=%b exp=0", bus.pndng_i_in); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== '0) $display("FAIL basic_pop_data got=%h exp=0", bus.data_out_i_in); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(0)) $display("FAIL basic_pop_count got=%0d exp=0", bus.count); else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'd0, 4'd1, 1'b0, 23'(i));
    total_cnt++; if (bus.full !== 1'b1) $display("FAIL fill_full got=%b exp=1", bus.full); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fill_no_ovf got=%b exp=0", bus.overflow); else pass_cnt++;
    push(4'd0, 4'd1, 1'b0, 23'd5);
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL fill_ovf got=%b exp=1", bus.overflow); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(4)) $display("FAIL fill_count got=%0d exp=4", bus.count); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd0, 4'd1, 1'b0, 23'(i)))
        $display("FAIL fill_order%0d got=%h exp=%h", i, bus.data_out_i_in, mk_pkt(4'd0, 4'd1, 1'b0, 23'(i))); else pass_cnt++;
      pop();
    end
    total_cnt++; if (bus.count !== CW'(0)) $display("FAIL fill_drain got=%0d exp=0", bus.count); else pass_cnt++;
    // pointers have wrapped back to slot 0; walk through slots 0 and 1 again
    push(4'd5, 4'd3, 1'b1, 23'd6);
    push(4'd5, 4'd4, 1'b0, 23'd7);
    total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd5, 4'd3, 1'b1, 23'd6))
      $display("FAIL wrap_head6 got=%h exp=%h", bus.data_out_i_in, mk_pkt(4'd5, 4'd3, 1'b1, 23'd6)); else pass_cnt++;
    pop();
    total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd5, 4'd4, 1'b0, 23'd7))
      $display("FAIL wrap_head7 got=%h exp=%h", bus.data_out_i_in, mk_pkt(4'd5, 4'd4, 1'b0, 23'd7)); else pass_cnt++;
    pop();
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 10; i <= 13; i++) push(4'd0, 4'd3, 1'b1, 23'(i));
    push_pop(4'd0, 4'd3, 1'b1, 23'd14);
    total_cnt++; if (bus.count !== CW'(3)) $display("FAIL fullpp_count got=%0d exp=3", bus.count); else pass_cnt++;
    total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL fullpp_ovf got=%b exp=1", bus.overflow); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL fullpp_full got=%b exp=0", bus.full); else pass_cnt++;
    for (int i = 11; i <= 13; i++) begin
      total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd0, 4'd3, 1'b1, 23'(i)))
        $display("FAIL fullpp_order%0d got=%h exp=%h", i, bus.data_out_i_in, mk_pkt(4'd0, 4'd3, 1'b1, 23'(i))); else pass_cnt++;
      pop();
    end
    total_cnt++; if (bus.pndng_i_in !== 1'b0) $display("FAIL fullpp_empty got=%b exp=0", bus.pndng_i_in); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(4'd2, 4'd0, 1'b0, 23'd20);
    push(4'd2, 4'd0, 1'b0, 23'd21);
    push_pop(4'd2, 4'd0, 1'b0, 23'd22);
    total_cnt++; if (bus.count !== CW'(2)) $display("FAIL b2b_count got=%0d exp=2", bus.count); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd2, 4'd0, 1'b0, 23'd21))
      $display("FAIL b2b_head21 got=%h exp=%h", bus.data_out_i_in, mk_pkt(4'd2, 4'd0, 1'b0, 23'd21)); else pass_cnt++;
    pop();
    total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd2, 4'd0, 1'b0, 23'd22))
      $display("FAIL b2b_head22 got=%h exp=%h", bus.data_out_i_in, mk_pkt(4'd2, 4'd0, 1'b0, 23'd22)); else pass_cnt++;
    pop();
    total_cnt++; if ({bus.count, bus.underflow} !== {CW'(0), 1'b0})
      $display("FAIL b2b_drain got=%0d/%b exp=0/0", bus.count, bus.underflow); else pass_cnt++;
  endtask

  task automatic test_underflow();
    do_reset();
    pop();
    total_cnt++; if (bus.underflow !== 1'b1) $display("FAIL udf_flag got=%b exp=1", bus.underflow); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(0)) $display("FAIL udf_count got=%0d exp=0", bus.count); else pass_cnt++;
    push_pop(4'd1, 4'd5, 1'b1, 23'h7FFFFF);
    total_cnt++; if (bus.count !== CW'(1)) $display("FAIL udf_pp_count got=%0d exp=1", bus.count); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== 40'h0015FFFFFF)
      $display("FAIL udf_pp_data got=%h exp=0015ffffff", bus.data_out_i_in); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    push(4'd3, 4'd0, 1'b0, 23'd31);
    push(4'd3, 4'd0, 1'b0, 23'd32);
    total_cnt++; if (bus.count !== CW'(3)) $display("FAIL mid_pre_count got=%0d exp=3", bus.count); else pass_cnt++;
    rst = 1'b1; bus.wr_en = 1'b1; bus.popin = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.wr_en = 1'b0; bus.popin = 1'b0;
    total_cnt++; if ({bus.count, bus.full, bus.overflow, bus.underflow, bus.bad_dst, bus.pndng_i_in} !== '0)
      $display("FAIL mid_reset got=%0d/%b%b%b%b%b exp=0/00000", bus.count, bus.full, bus.overflow,
               bus.underflow, bus.bad_dst, bus.pndng_i_in); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== '0) $display("FAIL mid_reset_data got=%h exp=0", bus.data_out_i_in); else pass_cnt++;
  endtask

  task automatic test_addr_chk();
    do_reset();
`ifdef INJ_ADDR_CHK_EN
    push(4'd1, 4'd1, 1'b0, 23'd40);
    total_cnt++; if (bus.bad_dst !== 1'b1) $display("FAIL chk_bad got=%b exp=1", bus.bad_dst); else pass_cnt++;
    total_cnt++; if (bus.count !== CW'(0)) $display("FAIL chk_bad_count got=%0d exp=0", bus.count); else pass_cnt++;
    push(4'd5, 4'd3, 1'b0, 23'd41);
    total_cnt++; if (bus.count !== CW'(1)) $display("FAIL chk_ok_count got=%0d exp=1", bus.count); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd5, 4'd3, 1'b0, 23'd41))
      $display("FAIL chk_ok_data got=%h exp=%h", bus.data_out_i_in, mk_pkt(4'd5, 4'd3, 1'b0, 23'd41)); else pass_cnt++;
    for (int i = 0; i < 3; i++) push(4'd0, 4'd4, 1'b0, 23'(42 + i));
    push(4'd0, 4'd0, 1'b0, 23'd50);
    total_cnt++; if ({bus.overflow, bus.bad_dst, bus.count} !== {2'b11, CW'(4)})
      $display("FAIL chk_full_bad got=%b%b/%0d exp=11/4", bus.overflow, bus.bad_dst, bus.count); else pass_cnt++;
`else
    push(4'd1, 4'd1, 1'b0, 23'd40);
    total_cnt++; if (bus.bad_dst !== 1'b0) $display("FAIL nochk_bad got=%b exp=0", bus.bad_dst); else pass_cnt++;
    total_cnt++; if (bus.data_out_i_in !== mk_pkt(4'd1, 4'd1, 1'b0, 23'd40))
      $display("FAIL nochk_data got=%h exp=%h", bus.data_out_i_in, mk_pkt(4'd1, 4'd1, 1'b0, 23'd40)); else pass_cnt++;
`endif
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.popin = 1'b0; bus.mode = 1'b0;
    bus.dst_row = '0; bus.dst_colum = '0; bus.payload = '0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_underflow();
    test_reset_midstream();
    test_addr_chk();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
